// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: producer / ALU / consumer bundle for the ALU command sequencer
//   slave  : sequencer side (accepts commands, drives ALU inputs, returns results)
//   master : environment side (producer, combinational ALU, consumer)
//   err_illegal exists only when ALU_SEQ_ILLEGAL_OP_EN is defined
interface alu_cmd_sequencer_if #(parameter int DEPTH = 4, parameter int CW = 3);
  localparam int CNTW = $clog2(DEPTH) + 1;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_a;
  logic [3:0]      in_b;
  logic [CW-1:0]   in_op;
  logic [3:0]      alu_a;
  logic [3:0]      alu_b;
  logic [CW-1:0]   alu_control;
  logic [3:0]      alu_result;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_result;
  logic [CW-1:0]   out_op;
  logic            out_zero;
  logic [CNTW-1:0] count;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic            err_illegal;
`endif
  modport slave (
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    output err_illegal,
`endif
    input  in_valid, in_a, in_b, in_op, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_control, out_valid, out_result, out_op, out_zero, count
  );
  modport master (
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    input  err_illegal,
`endif
    output in_valid, in_a, in_b, in_op, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_control, out_valid, out_result, out_op, out_zero, count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered issue stage in front of a combinational 4-bit ALU
//   clk, rst : single clock, synchronous active-high reset
//   bus      : alu_cmd_sequencer_if.slave (command in, ALU drive/return, result out, count)
//   ALU_SEQ_ILLEGAL_OP_EN : when defined, opcodes above 3'b100 are dropped and flag err_illegal
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic clk,
  input logic rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 8 + CW;
  typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd1, STALL = 2'd2} state_t;
  state_t        r_state;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic [3:0]    r_result;
  logic [CW-1:0] r_op;
  logic          r_zero;
  logic          w_empty;
  logic          w_full;
  logic          w_valid;
  logic          w_push;
  logic          w_wr;
  logic          w_fire;
  logic [EW-1:0] w_head;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_valid = r_state != IDLE;
  assign w_push  = bus.in_valid & ~w_full;
  // the output register can take a new result when it is empty or being drained this cycle
  assign w_fire  = ~w_empty & (~w_valid | bus.out_ready);
  assign w_head  = r_mem[r_rp];
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic r_err;
  logic w_legal;
  assign w_legal         = bus.in_op <= CW'(4);
  assign w_wr            = w_push & w_legal;
  assign bus.err_illegal = r_err;
  always_ff @(posedge clk)
    if (rst) r_err <= 1'b0;
    else if (w_push & ~w_legal) r_err <= 1'b1;
`else
  assign w_wr = w_push;
`endif
  assign bus.in_ready    = ~w_full;
  // an empty FIFO parks the ALU on its default opcode, which yields zero
  assign bus.alu_a       = w_empty ? 4'd0 : w_head[EW-1 -: 4];
  assign bus.alu_b       = w_empty ? 4'd0 : w_head[CW +: 4];
  assign bus.alu_control = w_empty ? '1 : w_head[CW-1:0];
  assign bus.out_valid   = w_valid;
  assign bus.out_result  = r_result;
  assign bus.out_op      = r_op;
  assign bus.out_zero    = r_zero;
  assign bus.count       = r_count;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= {bus.in_a, bus.in_b, bus.in_op};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_fire);
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_fire) begin
        r_rp     <= r_rp + 1'b1;
        r_result <= bus.alu_result;
        r_op     <= w_head[CW-1:0];
        r_zero   <= bus.alu_result == 4'd0;
        r_state  <= VALID;
      end else if (w_valid) begin
        r_state  <= bus.out_ready ? IDLE : STALL;
      end
    end
  end
endmodule
